// File: rtl/win_pkg.sv
// Shared definitions for the window generator and the ternary-weight convolution engine
// that sits downstream of it.
package win_pkg;

    localparam int DATA_W     = 6;
    localparam int INPUT_SIZE = 16;
    localparam int ADDR_BITS  = 4;

    typedef logic signed [DATA_W-1:0] pixel_t;

    // A window is complete only once two earlier rows and two earlier columns exist.
    function automatic logic window_ready(input int row, input int col);
        return (row >= 2) && (col >= 2);
    endfunction

endpackage

// File: rtl/lb_row.sv
// One feature-map row of pixel storage.
// The read is combinational and the write is synchronous, so the old value is seen during the write cycle.
module lb_row #(
    parameter int DEPTH     = win_pkg::INPUT_SIZE,
    parameter int ADDR_BITS = win_pkg::ADDR_BITS,
    parameter int DATA_W    = win_pkg::DATA_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [DATA_W-1:0]    wdata,
    output logic [DATA_W-1:0]    rdata
);

    logic [DATA_W-1:0] mem_reg [DEPTH];

    assign rdata = mem_reg[addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (we) begin
            mem_reg[addr] <= wdata;
        end
    end

endmodule

// File: rtl/window_generator.sv
// Raster-scan 3x3 sliding-window generator with two line buffers feeding a 3x3 tap array.
// Defining WINDOW_OUT_REG_EN adds one output register stage, which gives a total latency of 2 cycles.
module window_generator #(
    parameter int INPUT_SIZE = win_pkg::INPUT_SIZE,
    parameter int ADDR_BITS  = win_pkg::ADDR_BITS,
    parameter int DATA_W     = win_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] x11,
    output logic [DATA_W-1:0] x12,
    output logic [DATA_W-1:0] x13,
    output logic [DATA_W-1:0] x21,
    output logic [DATA_W-1:0] x22,
    output logic [DATA_W-1:0] x23,
    output logic [DATA_W-1:0] x31,
    output logic [DATA_W-1:0] x32,
    output logic [DATA_W-1:0] x33,
    output logic              fire,
    output logic              frame_done
);

    import win_pkg::window_ready;

    localparam logic [ADDR_BITS-1:0] LAST_IDX = ADDR_BITS'(INPUT_SIZE - 1);

    logic [ADDR_BITS-1:0] col_reg;
    logic [ADDR_BITS-1:0] row_reg;
    logic                 fire_reg;
    logic                 done_reg;
    logic [DATA_W-1:0]    lb0_rd;
    logic [DATA_W-1:0]    lb1_rd;
    logic [DATA_W-1:0]    row_in  [3];
    logic [DATA_W-1:0]    tap_all [9];
    logic [DATA_W-1:0]    tap_out [9];
    logic                 fire_out;
    logic                 done_out;

    // lb0 holds row r-1 and lb1 holds row r-2. Each accepted pixel pushes its column down one row.
    lb_row #(.DEPTH(INPUT_SIZE), .ADDR_BITS(ADDR_BITS), .DATA_W(DATA_W)) lb0 (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (in_valid),
        .addr  (col_reg),
        .wdata (data_in),
        .rdata (lb0_rd)
    );

    lb_row #(.DEPTH(INPUT_SIZE), .ADDR_BITS(ADDR_BITS), .DATA_W(DATA_W)) lb1 (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (in_valid),
        .addr  (col_reg),
        .wdata (lb0_rd),
        .rdata (lb1_rd)
    );

    assign row_in[0] = lb1_rd;
    assign row_in[1] = lb0_rd;
    assign row_in[2] = data_in;

    // Each tap row is a 3-deep shift register; the newest column enters at index 2.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_tap_row
            logic [DATA_W-1:0] tap_reg [3];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    tap_reg[0] <= '0;
                    tap_reg[1] <= '0;
                    tap_reg[2] <= '0;
                end else if (in_valid) begin
                    tap_reg[0] <= tap_reg[1];
                    tap_reg[1] <= tap_reg[2];
                    tap_reg[2] <= row_in[gi];
                end
            end

            assign tap_all[gi*3 + 0] = tap_reg[0];
            assign tap_all[gi*3 + 1] = tap_reg[1];
            assign tap_all[gi*3 + 2] = tap_reg[2];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_reg  <= '0;
            row_reg  <= '0;
            fire_reg <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            fire_reg <= in_valid && window_ready(int'(row_reg), int'(col_reg));
            done_reg <= in_valid && (row_reg == LAST_IDX) && (col_reg == LAST_IDX);
            if (in_valid) begin
                if (col_reg == LAST_IDX) begin
                    col_reg <= '0;
                    row_reg <= (row_reg == LAST_IDX) ? '0 : row_reg + 1'b1;
                end else begin
                    col_reg <= col_reg + 1'b1;
                end
            end
        end
    end

`ifdef WINDOW_OUT_REG_EN
    generate
        for (genvar gi = 0; gi < 9; gi++) begin : g_out_reg
            logic [DATA_W-1:0] out_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_reg <= '0;
                end else begin
                    out_reg <= tap_all[gi];
                end
            end

            assign tap_out[gi] = out_reg;
        end
    endgenerate

    logic fire_q_reg;
    logic done_q_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fire_q_reg <= 1'b0;
            done_q_reg <= 1'b0;
        end else begin
            fire_q_reg <= fire_reg;
            done_q_reg <= done_reg;
        end
    end

    assign fire_out = fire_q_reg;
    assign done_out = done_q_reg;
`else
    generate
        for (genvar gi = 0; gi < 9; gi++) begin : g_out_pass
            assign tap_out[gi] = tap_all[gi];
        end
    endgenerate

    assign fire_out = fire_reg;
    assign done_out = done_reg;
`endif

    assign x11        = tap_out[0];
    assign x12        = tap_out[1];
    assign x13        = tap_out[2];
    assign x21        = tap_out[3];
    assign x22        = tap_out[4];
    assign x23        = tap_out[5];
    assign x31        = tap_out[6];
    assign x32        = tap_out[7];
    assign x33        = tap_out[8];
    assign fire       = fire_out;
    assign frame_done = done_out;

endmodule
